branch_compare_unit: RTL and testbench

Iterative, parametrised branch-condition evaluator for the RISC-V execute stage. It accepts two WIDTH-bit operands and a funct3 branch opcode over a valid/ready handshake. It subtracts them CHUNK bits per cycle with a rippled borrow and returns the taken/not-taken decision over a second valid/ready handshake. It covers all six RV32/RV64 branch conditions, flags illegal opcodes, and supports pipeline flush.

---
 rtl/branch_compare_unit.sv | 195 +++++++++++++++++++
 tb/tb_branch_compare_unit.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_compare_unit.sv
`default_nettype none
// ============================================================================
// Module : branch_compare_unit
// Desc   : Chunk-serial RISC-V branch condition evaluator, valid/ready on both sides.
// Rev    : 1.0
// ============================================================================
module branch_compare_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             r_o,
  output logic             illegal_o
);

  localparam int NBEATS = WIDTH / CHUNK;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(NBEATS - 1);

  localparam logic [2:0] C_OP_BEQ  = 3'b000;
  localparam logic [2:0] C_OP_BNE  = 3'b001;
  localparam logic [2:0] C_OP_BLT  = 3'b100;
  localparam logic [2:0] C_OP_BGE  = 3'b101;
  localparam logic [2:0] C_OP_BLTU = 3'b110;
  localparam logic [2:0] C_OP_BGEU = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             a_sign_q, a_sign_d;
  logic             b_sign_q, b_sign_d;
  logic             borrow_q, borrow_d;
  logic             neq_q, neq_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             r_q, r_d;
  logic             illegal_q, illegal_d;

  logic [WIDTH-1:0] w_a_shift;
  logic [WIDTH-1:0] w_b_shift;
  logic [CHUNK-1:0] w_a_k;
  logic [CHUNK-1:0] w_b_k;
  logic             w_borrow_n;
  logic             w_neq_n;
  logic             w_eq;
  logic             w_lt;
  logic             w_taken;
  logic             w_illegal;

  // Operands are shifted right one chunk per beat so the active chunk is always the low slice.
  generate
    if (NBEATS > 1) begin : g_shift_multi
      assign w_a_shift = {{CHUNK{1'b0}}, a_q[WIDTH-1:CHUNK]};
      assign w_b_shift = {{CHUNK{1'b0}}, b_q[WIDTH-1:CHUNK]};
    end else begin : g_shift_single
      assign w_a_shift = a_q;
      assign w_b_shift = b_q;
    end
  endgenerate

  assign w_a_k = a_q[CHUNK-1:0];
  assign w_b_k = b_q[CHUNK-1:0];

  // Borrow-out of (a_k - b_k - borrow_in), expressed without the unused difference bits.
  assign w_borrow_n = (w_a_k < w_b_k) | ((w_a_k == w_b_k) & borrow_q);
  assign w_neq_n    = neq_q | (w_a_k != w_b_k);
  assign w_eq       = ~w_neq_n;
  assign w_lt       = (a_sign_q ^ b_sign_q) ? a_sign_q : w_borrow_n;

  always_comb begin
    w_taken   = 1'b0;
    w_illegal = 1'b0;
    case (op_q)
      C_OP_BEQ:  w_taken = w_eq;
      C_OP_BNE:  w_taken = ~w_eq;
      C_OP_BLT:  w_taken = w_lt;
      C_OP_BGE:  w_taken = ~w_lt;
      C_OP_BLTU: w_taken = w_borrow_n;
      C_OP_BGEU: w_taken = ~w_borrow_n;
      default:   w_illegal = 1'b1;
    endcase
  end

  assign ready_o   = (state_q == S_IDLE) & ~flush_i;
  assign valid_o   = valid_q;
  assign r_o       = r_q;
  assign illegal_o = illegal_q;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    a_sign_d  = a_sign_q;
    b_sign_d  = b_sign_q;
    borrow_d  = borrow_q;
    neq_d     = neq_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    r_d       = r_q;
    illegal_d = illegal_q;

    if (flush_i) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid_i) begin
            a_d      = a_i;
            b_d      = b_i;
            op_d     = op_i;
            a_sign_d = a_i[WIDTH-1];
            b_sign_d = b_i[WIDTH-1];
            borrow_d = 1'b0;
            neq_d    = 1'b0;
            cnt_d    = '0;
            state_d  = S_BUSY;
          end
        end
        S_BUSY: begin
          a_d      = w_a_shift;
          b_d      = w_b_shift;
          borrow_d = w_borrow_n;
          neq_d    = w_neq_n;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == C_LAST_BEAT) begin
            state_d   = S_DONE;
            valid_d   = 1'b1;
            r_d       = w_taken & ~w_illegal;
            illegal_d = w_illegal;
          end
        end
        S_DONE: begin
          if (ready_i) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      a_sign_q  <= 1'b0;
      b_sign_q  <= 1'b0;
      borrow_q  <= 1'b0;
      neq_q     <= 1'b0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      r_q       <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      a_sign_q  <= a_sign_d;
      b_sign_q  <= b_sign_d;
      borrow_q  <= borrow_d;
      neq_q     <= neq_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      r_q       <= r_d;
      illegal_q <= illegal_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_compare_unit.sv
`default_nettype none
// Bench for branch_compare_unit: three configurations share stimulus; results are
// checked against a reference model through an expected-result queue.
module tb_branch_compare_unit;

  typedef struct packed {
    logic r;
    logic ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        ready = 1'b0;
  logic        flush = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic [2:0]  op = '0;
  logic [1:0]  sel = 2'd0;
  logic [2:0]  rdy_v, val_v, r_v, ill_v;
  logic        rdy_s, val_s, r_s, ill_s;
  exp_t        sb[$];
  exp_t        last_e;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  assign rdy_s = rdy_v[sel];
  assign val_s = val_v[sel];
  assign r_s   = r_v[sel];
  assign ill_s = ill_v[sel];

  branch_compare_unit #(.WIDTH(32), .CHUNK(8)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid && sel == 2'd0), .ready_o(rdy_v[0]),
    .a_i(a[31:0]), .b_i(b[31:0]), .op_i(op), .flush_i(flush),
    .valid_o(val_v[0]), .ready_i(ready), .r_o(r_v[0]), .illegal_o(ill_v[0]));

  branch_compare_unit #(.WIDTH(64), .CHUNK(64)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid && sel == 2'd1), .ready_o(rdy_v[1]),
    .a_i(a), .b_i(b), .op_i(op), .flush_i(flush),
    .valid_o(val_v[1]), .ready_i(ready), .r_o(r_v[1]), .illegal_o(ill_v[1]));

  branch_compare_unit #(.WIDTH(16), .CHUNK(1)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid && sel == 2'd2), .ready_o(rdy_v[2]),
    .a_i(a[15:0]), .b_i(b[15:0]), .op_i(op), .flush_i(flush),
    .valid_o(val_v[2]), .ready_i(ready), .r_o(r_v[2]), .illegal_o(ill_v[2]));

  function automatic int cfg_w(input logic [1:0] s);
    case (s)
      2'd0:    return 32;
      2'd1:    return 64;
      default: return 16;
    endcase
  endfunction

  function automatic int cfg_nb(input logic [1:0] s);
    case (s)
      2'd0:    return 4;
      2'd1:    return 1;
      default: return 16;
    endcase
  endfunction

  function automatic exp_t model(input int w, input logic [63:0] x, input logic [63:0] y,
                                 input logic [2:0] o);
    logic [63:0]        mask, xm, ym;
    logic signed [63:0] xs, ys;
    logic               eq, ltu, lt;
    exp_t               e;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    xm   = x & mask;
    ym   = y & mask;
    xs   = $signed(xm << (64 - w)) >>> (64 - w);
    ys   = $signed(ym << (64 - w)) >>> (64 - w);
    eq   = (xm == ym);
    ltu  = (xm < ym);
    lt   = (xs < ys);
    e    = '{r: 1'b0, ill: 1'b0};
    case (o)
      3'b000:  e.r = eq;
      3'b001:  e.r = ~eq;
      3'b100:  e.r = lt;
      3'b101:  e.r = ~lt;
      3'b110:  e.r = ltu;
      3'b111:  e.r = ~ltu;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic issue(input logic [63:0] x, input logic [63:0] y, input logic [2:0] o);
    logic acc;
    int   guard;
    a = x; b = y; op = o; valid = 1'b1;
    sb.push_back(model(cfg_w(sel), x, y, o));
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 50) begin
      #1 acc = rdy_s;
      @(negedge clk);
      guard++;
    end
    valid = 1'b0;
    a = ~x; b = ~y; op = ~o;
    if (!acc) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout cfg%0d: ready_o never high", sel);
    end
  endtask

  task automatic wait_result(input string name);
    int   lat;
    exp_t e;
    lat = 0;
    #1;
    n_tests++;
    if (rdy_s !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_ready_busy cfg%0d: ready_o=%b want 0", name, sel, rdy_s);
    end
    while (val_s !== 1'b1 && lat < 64) begin
      @(negedge clk); #1;
      lat++;
    end
    n_tests++;
    if (val_s !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_timeout cfg%0d: valid_o=%b want 1", name, sel, val_s);
      if (sb.size() > 0) e = sb.pop_front();
    end else begin
      if (lat != cfg_nb(sel)) begin
        n_fail++;
        $display("FAIL %s_latency cfg%0d: got %0d want %0d", name, sel, lat, cfg_nb(sel));
      end
      e = sb.pop_front();
      last_e = e;
      n_tests++;
      if ({r_s, ill_s} !== {e.r, e.ill}) begin
        n_fail++;
        $display("FAIL %s cfg%0d: r/ill got %b%b want %b%b", name, sel, r_s, ill_s, e.r, e.ill);
      end
    end
  endtask

  task automatic consume();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    #1;
    n_tests++;
    if ({val_s, rdy_s} !== 2'b01) begin
      n_fail++;
      $display("FAIL consume cfg%0d: valid/ready got %b%b want 01", sel, val_s, rdy_s);
    end
  endtask

  task automatic run(input logic [63:0] x, input logic [63:0] y, input logic [2:0] o,
                     input string name);
    issue(x, y, o);
    wait_result(name);
    consume();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if ({rdy_v[k], val_v[k], r_v[k], ill_v[k]} !== 4'b1000) begin
        n_fail++;
        $display("FAIL reset cfg%0d: rdy/val/r/ill got %b%b%b%b want 1000",
                 k, rdy_v[k], val_v[k], r_v[k], ill_v[k]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_branch_ops();
    logic [63:0] ones, msb, x, y;
    logic [2:0]  ops[6];
    ones = 64'hFFFF_FFFF_FFFF_FFFF;
    msb  = 64'd1 << (cfg_w(sel) - 1);
    ops  = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
    run(64'h12345678, 64'h12345678, 3'b000, "beq_equal");
    run(64'h12345678, 64'h12345678, 3'b001, "bne_equal");
    run(ones, 64'h1, 3'b100, "blt_neg");
    run(ones, 64'h1, 3'b110, "bltu_neg");
    run(ones, 64'h1, 3'b111, "bgeu_neg");
    run(64'h100, 64'hFF, 3'b110, "bltu_xborrow");
    run(64'hFF, 64'h100, 3'b110, "bltu_xborrow_swap");
    run(msb, msb | 64'h1, 3'b100, "blt_same_sign");
    for (int i = 0; i < 4; i++) begin
      x = {$urandom, $urandom};
      y = (i % 2 == 1) ? x : {$urandom, $urandom};
      run(x, y, ops[$urandom_range(0, 5)], "random_op");
    end
  endtask

  task automatic test_illegal_backpressure();
    issue(64'h5, 64'h5, 3'b010);
    wait_result("illegal_010");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      n_tests++;
      if ({val_s, rdy_s, r_s, ill_s} !== {1'b1, 1'b0, last_e.r, last_e.ill}) begin
        n_fail++;
        $display("FAIL backpressure cfg%0d: val/rdy/r/ill got %b%b%b%b want 10%b%b",
                 sel, val_s, rdy_s, r_s, ill_s, last_e.r, last_e.ill);
      end
    end
    consume();
    run(64'h7, 64'h3, 3'b011, "illegal_011");
  endtask

  task automatic test_flush();
    int seen;
    exp_t e;
    issue(64'h1234, 64'h1234, 3'b000);
    if (cfg_nb(sel) > 1) @(negedge clk);
    flush = 1'b1;
    #1;
    n_tests++;
    if (rdy_s !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ready_low cfg%0d: ready_o=%b want 0", sel, rdy_s);
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_tests++;
    if ({val_s, rdy_s} !== 2'b01) begin
      n_fail++;
      $display("FAIL flush_idle cfg%0d: valid/ready got %b%b want 01", sel, val_s, rdy_s);
    end
    if (sb.size() > 0) e = sb.pop_back();
    seen = 0;
    for (int i = 0; i < cfg_nb(sel) + 2; i++) begin
      @(negedge clk); #1;
      if (val_s === 1'b1) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL flush_no_valid cfg%0d: valid_o seen %0d cycles want 0", sel, seen);
    end
    // Request raised together with flush in IDLE must not be accepted.
    a = 64'h9; b = 64'h9; op = 3'b000;
    valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    valid = 1'b0; flush = 1'b0;
    seen = 0;
    for (int i = 0; i < cfg_nb(sel) + 2; i++) begin
      @(negedge clk); #1;
      if (val_s === 1'b1 || rdy_s !== 1'b1) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL flush_no_handshake cfg%0d: bad cycles got %0d want 0", sel, seen);
    end
    run(64'h5, 64'h5, 3'b101, "bge_after_flush");
  endtask

  task automatic test_back_to_back();
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(64'h40 + 64'(i), 64'h41, 3'b100);
      wait_result("back_to_back");
    end
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic test_async_reset();
    exp_t e;
    run(64'h77, 64'h77, 3'b000, "pre_reset_beq");
    issue(64'h1, 64'h2, 3'b001);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({val_s, r_s, ill_s} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_busy cfg%0d: val/r/ill got %b%b%b want 000", sel, val_s, r_s, ill_s);
    end
    if (sb.size() > 0) e = sb.pop_back();
    #1 rst = 1'b0;
    @(negedge clk); #1;
    n_tests++;
    if ({val_s, rdy_s} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_busy_idle cfg%0d: valid/ready got %b%b want 01", sel, val_s, rdy_s);
    end
    issue(64'h3, 64'h4, 3'b010);
    wait_result("pre_reset_done");
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if ({val_s, r_s, ill_s} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_done cfg%0d: val/r/ill got %b%b%b want 000", sel, val_s, r_s, ill_s);
    end
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      test_branch_ops();
      test_illegal_backpressure();
      test_flush();
      test_back_to_back();
      test_async_reset();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
